// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports, registered reads,
// optional write bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_RD-1:0]          RdEn,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    input  logic [1:0]                 WrEn,
    input  logic [2*ADDR_W-1:0]        WrAddr,
    input  logic [2*DATA_W-1:0]        WrData,
    input  logic                       ResvEn,
    input  logic [ADDR_W-1:0]          ResvAddr,
    input  logic [ADDR_W-1:0]          DbgAddr,
    output logic [DATA_W-1:0]          DbgData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem      [DEPTH];
    logic              busy     [DEPTH];
    logic [DATA_W-1:0] mem_nxt  [DEPTH];
    logic              busy_nxt [DEPTH];

    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;

    assign wr_addr0 = WrAddr[0 +: ADDR_W];
    assign wr_addr1 = WrAddr[ADDR_W +: ADDR_W];
    assign wr_data0 = WrData[0 +: DATA_W];
    assign wr_data1 = WrData[DATA_W +: DATA_W];

    // Post-edge image of every register; also feeds the read bypass.
    // Port 1 is applied after port 0 so it wins, and the reservation last.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i]  = mem[i];
            busy_nxt[i] = busy[i];
            if (WrEn[0] && wr_addr0 == ADDR_W'(i)) begin
                mem_nxt[i]  = wr_data0;
                busy_nxt[i] = 1'b0;
            end
            if (WrEn[1] && wr_addr1 == ADDR_W'(i)) begin
                mem_nxt[i]  = wr_data1;
                busy_nxt[i] = 1'b0;
            end
            if (ResvEn && ResvAddr == ADDR_W'(i)) begin
                busy_nxt[i] = 1'b1;
            end
            if (ZERO_REG != 0 && i == 0) begin
                mem_nxt[i]  = '0;
                busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem  <= '{default: '0};
            busy <= '{default: 1'b0};
        end else begin
            mem  <= mem_nxt;
            busy <= busy_nxt;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              is_zero;
            logic [DATA_W-1:0] data_src;
            logic              busy_src;
            logic [DATA_W-1:0] data_q;
            logic              busy_q;

            assign ra      = RdAddr[k*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (ra == '0);

            always_comb begin
                data_src = mem[ra];
                busy_src = busy[ra];
                if (BYPASS != 0) begin
                    data_src = mem_nxt[ra];
                    busy_src = busy_nxt[ra];
                end
                if (is_zero) begin
                    data_src = '0;
                    busy_src = 1'b0;
                end
            end

            always_ff @(posedge Clk) begin
                if (Rst) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                end else if (RdEn[k]) begin
                    data_q <= data_src;
                    busy_q <= busy_src;
                end
            end

            assign RdData[k*DATA_W +: DATA_W] = data_q;
            assign RdBusy[k] = busy_q;
        end
    endgenerate

    // Debug view sees committed storage only, never the bypass path.
    always_comb begin
        DbgData = mem[DbgAddr];
        if (ZERO_REG != 0 && DbgAddr == '0) begin
            DbgData = '0;
        end
    end

endmodule
